// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: merges ALU, FPU and input-byte results onto the register-file
// write ports, and tracks per-register pending-write reservations for both files.
module core_wb_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ALU_VALID,
  output logic        ALU_READY,
  input  logic [4:0]  ALU_ADDR,
  input  logic [31:0] ALU_DATA,
  input  logic        FPU_VALID,
  output logic        FPU_READY,
  input  logic [4:0]  FPU_ADDR,
  input  logic [31:0] FPU_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [4:0]  IN_ADDR,
  input  logic [7:0]  IN_DATA,
  input  logic        ISSUE_VALID,
  input  logic        ISSUE_FP,
  input  logic [4:0]  ISSUE_ADDR,
  output logic        WE,
  output logic [4:0]  WADDR,
  output logic [4:0]  FWADDR,
  output logic [31:0] WDATA,
  output logic        INE,
  output logic [7:0]  INDATA,
  output logic [31:0] BUSY_INT,
  output logic [31:0] BUSY_FP
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_FPU = 2'd1,
    SRC_IN  = 2'd2
  } src_e;

  src_e        ptr, ptr_next;
  logic [2:0]  valid_vec, rot_valid, rot_grant, grant;
  logic [31:0] set_int, set_fp, clr_int, clr_fp;

  assign valid_vec = {IN_VALID, FPU_VALID, ALU_VALID};

  // Rotate so the requester under the pointer sits in bit 0, keep the lowest set
  // bit, then rotate the one-hot result back into requester order.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rot_valid = valid_vec;
    grant     = '0;
    case (ptr)
      SRC_FPU: rot_valid = {valid_vec[0], valid_vec[2], valid_vec[1]};
      SRC_IN:  rot_valid = {valid_vec[1], valid_vec[0], valid_vec[2]};
      default: rot_valid = valid_vec;
    endcase
    rot_grant = rot_valid & (~rot_valid + 3'd1);
    case (ptr)
      SRC_FPU: grant = {rot_grant[1], rot_grant[0], rot_grant[2]};
      SRC_IN:  grant = {rot_grant[0], rot_grant[2], rot_grant[1]};
      default: grant = rot_grant;
    endcase
    if (!RR_EN) grant = valid_vec & (~valid_vec + 3'd1);
  end

  always_comb begin
    ptr_next = ptr;
    if (RR_EN) begin
      if (grant[0])      ptr_next = SRC_FPU;
      else if (grant[1]) ptr_next = SRC_IN;
      else if (grant[2]) ptr_next = SRC_ALU;
    end
  end

  // Readiness is forced low while reset is held, independent of the pointer.
  assign ALU_READY = grant[0] & RST_N;
  assign FPU_READY = grant[1] & RST_N;
  assign IN_READY  = grant[2] & RST_N;

  always_comb begin
    set_int = '0;
    set_fp  = '0;
    clr_int = '0;
    clr_fp  = '0;
    if (ISSUE_VALID) begin
      if (ISSUE_FP) set_fp[ISSUE_ADDR]  = 1'b1;
      else          set_int[ISSUE_ADDR] = 1'b1;
    end
    if (grant[0]) clr_int[ALU_ADDR] = 1'b1;
    if (grant[2]) clr_int[IN_ADDR]  = 1'b1;
    if (grant[1]) clr_fp[FPU_ADDR]  = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= SRC_ALU;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ptr <= ptr_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WE     <= 1'b0;
      INE    <= 1'b0;
      WADDR  <= '0;
      FWADDR <= '0;
      WDATA  <= '0;
      INDATA <= '0;
    end else begin
      WE     <= grant[0] | grant[1];
      INE    <= grant[2];
      WADDR  <= grant[0] ? ALU_ADDR : (grant[2] ? IN_ADDR : 5'd0);
      FWADDR <= grant[1] ? FPU_ADDR : 5'd0;
      if (grant[0])      WDATA <= ALU_DATA;
      else if (grant[1]) WDATA <= FPU_DATA;
      if (grant[2])      INDATA <= IN_DATA;
    end
  end

  // Set is applied after clear so a same-edge reservation survives; bit 0 never sets.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUSY_INT <= '0;
      BUSY_FP  <= '0;
    end else begin
      BUSY_INT <= ((BUSY_INT & ~clr_int) | set_int) & 32'hFFFF_FFFE;
      BUSY_FP  <= ((BUSY_FP  & ~clr_fp)  | set_fp)  & 32'hFFFF_FFFE;
    end
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Scoreboard bench for core_wb_arbiter: round-robin and fixed-priority instances share
// stimulus; a reference model pushes expected registered outputs, a monitor pops them.
module tb_core_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic        ine;
    logic [4:0]  waddr;
    logic [4:0]  fwaddr;
    logic [31:0] wdata;
    logic [7:0]  indata;
    logic [31:0] bint;
    logic [31:0] bfp;
  } exp_t;

  typedef struct packed {
    int          ptr;
    logic [31:0] bint;
    logic [31:0] bfp;
    logic [31:0] wdata;
    logic [7:0]  indata;
  } mstate_t;

  typedef struct packed {
    exp_t rr;
    exp_t fx;
  } pair_t;

  logic        clk, rst_n;
  logic        alu_valid, fpu_valid, in_valid, issue_valid, issue_fp;
  logic [4:0]  alu_addr, fpu_addr, in_addr, issue_addr;
  logic [31:0] alu_data, fpu_data;
  logic [7:0]  in_data;

  logic        rr_alu_ready, rr_fpu_ready, rr_in_ready, rr_we, rr_ine;
  logic [4:0]  rr_waddr, rr_fwaddr;
  logic [31:0] rr_wdata, rr_busy_int, rr_busy_fp;
  logic [7:0]  rr_indata;
  logic        fx_alu_ready, fx_fpu_ready, fx_in_ready, fx_we, fx_ine;
  logic [4:0]  fx_waddr, fx_fwaddr;
  logic [31:0] fx_wdata, fx_busy_int, fx_busy_fp;
  logic [7:0]  fx_indata;

  int      checks   = 0;
  int      failures = 0;
  bit      mon_en   = 1'b0;
  pair_t   exp_q[$];
  pair_t   mon_p;
  mstate_t m_rr, m_fx;

  core_wb_arbiter #(.RR_EN(1'b1)) dut_rr (
    .CLK(clk), .RST_N(rst_n),
    .ALU_VALID(alu_valid), .ALU_READY(rr_alu_ready), .ALU_ADDR(alu_addr), .ALU_DATA(alu_data),
    .FPU_VALID(fpu_valid), .FPU_READY(rr_fpu_ready), .FPU_ADDR(fpu_addr), .FPU_DATA(fpu_data),
    .IN_VALID(in_valid), .IN_READY(rr_in_ready), .IN_ADDR(in_addr), .IN_DATA(in_data),
    .ISSUE_VALID(issue_valid), .ISSUE_FP(issue_fp), .ISSUE_ADDR(issue_addr),
    .WE(rr_we), .WADDR(rr_waddr), .FWADDR(rr_fwaddr), .WDATA(rr_wdata),
    .INE(rr_ine), .INDATA(rr_indata), .BUSY_INT(rr_busy_int), .BUSY_FP(rr_busy_fp)
  );

  core_wb_arbiter #(.RR_EN(1'b0)) dut_fx (
    .CLK(clk), .RST_N(rst_n),
    .ALU_VALID(alu_valid), .ALU_READY(fx_alu_ready), .ALU_ADDR(alu_addr), .ALU_DATA(alu_data),
    .FPU_VALID(fpu_valid), .FPU_READY(fx_fpu_ready), .FPU_ADDR(fpu_addr), .FPU_DATA(fpu_data),
    .IN_VALID(in_valid), .IN_READY(fx_in_ready), .IN_ADDR(in_addr), .IN_DATA(in_data),
    .ISSUE_VALID(issue_valid), .ISSUE_FP(issue_fp), .ISSUE_ADDR(issue_addr),
    .WE(fx_we), .WADDR(fx_waddr), .FWADDR(fx_fwaddr), .WDATA(fx_wdata),
    .INE(fx_ine), .INDATA(fx_indata), .BUSY_INT(fx_busy_int), .BUSY_FP(fx_busy_fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pick the winner by scanning requesters in priority order, then
  // apply the transfer and reservation rules to the architectural state.
  function automatic void model_step(input bit rr, input mstate_t s, output mstate_t n,
                                     output exp_t e, output logic [2:0] g);
    logic [2:0] v;
    int who;
    v   = {in_valid, fpu_valid, alu_valid};
    who = -1;
    n   = s;
    g   = '0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = rr ? (s.ptr + k) % 3 : k;
      if (who < 0 && v[idx]) who = idx;
    end
    e.we = 1'b0; e.ine = 1'b0; e.waddr = '0; e.fwaddr = '0;
    e.wdata = s.wdata; e.indata = s.indata;
    case (who)
      0: begin g = 3'b001; e.we = 1'b1; e.waddr = alu_addr; e.wdata = alu_data; n.bint[alu_addr] = 1'b0; end
      1: begin g = 3'b010; e.we = 1'b1; e.fwaddr = fpu_addr; e.wdata = fpu_data; n.bfp[fpu_addr] = 1'b0; end
      2: begin g = 3'b100; e.ine = 1'b1; e.waddr = in_addr; e.indata = in_data; n.bint[in_addr] = 1'b0; end
      default: ;
    endcase
    if (rr && who >= 0) n.ptr = (who + 1) % 3;
    if (issue_valid) begin
      if (issue_fp) n.bfp[issue_addr] = 1'b1;
      else          n.bint[issue_addr] = 1'b1;
    end
    n.bint[0] = 1'b0;
    n.bfp[0]  = 1'b0;
    n.wdata   = e.wdata;
    n.indata  = e.indata;
    e.bint    = n.bint;
    e.bfp     = n.bfp;
  endfunction

  // Drives one cycle of inputs (called just after a falling edge), checks the
  // combinational READYs and queues the outputs expected after the next rising edge.
  task automatic apply(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                       input logic iv, input logic [4:0] ia, input logic [7:0] idt,
                       input logic sv, input logic sfp, input logic [4:0] sa);
    exp_t       e_rr, e_fx;
    mstate_t    n_rr, n_fx;
    logic [2:0] g_rr, g_fx;
    pair_t      p;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    fpu_valid = fv; fpu_addr = fa; fpu_data = fd;
    in_valid = iv; in_addr = ia; in_data = idt;
    issue_valid = sv; issue_fp = sfp; issue_addr = sa;
    #1;
    model_step(1'b1, m_rr, n_rr, e_rr, g_rr);
    model_step(1'b0, m_fx, n_fx, e_fx, g_fx);
    check("rr_ready", 64'({rr_in_ready, rr_fpu_ready, rr_alu_ready}), 64'(g_rr));
    check("fx_ready", 64'({fx_in_ready, fx_fpu_ready, fx_alu_ready}), 64'(g_fx));
    m_rr = n_rr;
    m_fx = n_fx;
    p.rr = e_rr;
    p.fx = e_fx;
    exp_q.push_back(p);
  endtask

  task automatic apply_idle();
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic cmp_side(input string tag, input exp_t e, input logic we, input logic ine,
                          input logic [4:0] wa, input logic [4:0] fwa, input logic [31:0] wd,
                          input logic [7:0] id, input logic [31:0] bi, input logic [31:0] bf);
    check({tag, "_we"},       64'(we),  64'(e.we));
    check({tag, "_ine"},      64'(ine), 64'(e.ine));
    check({tag, "_waddr"},    64'(wa),  64'(e.waddr));
    check({tag, "_fwaddr"},   64'(fwa), 64'(e.fwaddr));
    check({tag, "_wdata"},    64'(wd),  64'(e.wdata));
    check({tag, "_indata"},   64'(id),  64'(e.indata));
    check({tag, "_busy_int"}, 64'(bi),  64'(e.bint));
    check({tag, "_busy_fp"},  64'(bf),  64'(e.bfp));
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got empty queue expected one entry");
      end else begin
        mon_p = exp_q.pop_front();
        cmp_side("rr", mon_p.rr, rr_we, rr_ine, rr_waddr, rr_fwaddr, rr_wdata, rr_indata,
                 rr_busy_int, rr_busy_fp);
        cmp_side("fx", mon_p.fx, fx_we, fx_ine, fx_waddr, fx_fwaddr, fx_wdata, fx_indata,
                 fx_busy_int, fx_busy_fp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    64'({rr_in_ready, rr_fpu_ready, rr_alu_ready, fx_in_ready, fx_fpu_ready, fx_alu_ready}), 64'd0);
    check({tag, "_we_ine"},   64'({rr_we, rr_ine, fx_we, fx_ine}), 64'd0);
    check({tag, "_addr"},     64'({rr_waddr, rr_fwaddr, fx_waddr, fx_fwaddr}), 64'd0);
    check({tag, "_wdata"},    64'(rr_wdata), 64'd0);
    check({tag, "_indata"},   64'(rr_indata), 64'd0);
    check({tag, "_busy_int"}, 64'(rr_busy_int | fx_busy_int), 64'd0);
    check({tag, "_busy_fp"},  64'(rr_busy_fp | fx_busy_fp), 64'd0);
  endtask

  initial begin
    logic [2:0] rr_seq [4];
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
    m_rr = '0;
    m_fx = '0;
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1111_1111;
    fpu_valid = 1'b1; fpu_addr = 5'd2; fpu_data = 32'h2222_2222;
    in_valid = 1'b1;  in_addr = 5'd3;  in_data = 8'h33;
    issue_valid = 1'b1; issue_fp = 1'b0; issue_addr = 5'd6;
    #12;
    check_reset_outputs("por");

    // Release reset; all three requesters held high rotate ALU, FPU, IN, ALU.
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      apply(1'b1, 5'(1 + i), 32'hA000_0000 + 32'(i), 1'b1, 5'(9 + i), 32'hF000_0000 + 32'(i),
            1'b1, 5'(17 + i), 8'(8'hC0 + i), 1'b0, 1'b0, 5'd0);
      check("rr_rotation", 64'({rr_in_ready, rr_fpu_ready, rr_alu_ready}), 64'(rr_seq[i]));
    end

    @(negedge clk);
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h3F80_0000, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #2;
    check("fpu_write", 64'({rr_we, rr_fwaddr, rr_waddr}), 64'({1'b1, 5'd7, 5'd0}));
    check("fpu_wdata", 64'(rr_wdata), 64'h3F80_0000);

    @(negedge clk);
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 8'hA5, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #2;
    check("in_write", 64'({rr_ine, rr_we, rr_waddr, rr_indata}), 64'({1'b1, 1'b0, 5'd5, 8'hA5}));

    // Reservation set, cleared by the write, then a same-edge set and clear.
    @(negedge clk);
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 5'd3);
    @(posedge clk); #2;
    check("busy_set", 64'(rr_busy_int), 64'h0000_0008);
    @(negedge clk);
    apply(1'b1, 5'd3, 32'h0BAD_F00D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #2;
    check("busy_clear", 64'(rr_busy_int), 64'd0);
    @(negedge clk);
    apply(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 5'd3);
    @(posedge clk); #2;
    check("busy_set_wins", 64'(rr_busy_int), 64'h0000_0008);

    // Fixed priority: FPU starves while ALU holds its request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(1'b1, 5'd4, 32'(i), 1'b1, 5'd8, 32'hBEEF_0000, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0);
      check("fx_fpu_starved", 64'({fx_fpu_ready, fx_alu_ready}), 64'b01);
    end
    @(negedge clk);
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hBEEF_0000, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0);
    check("fx_fpu_granted", 64'(fx_fpu_ready), 64'd1);

    // Randomized traffic; small address range forces reservation collisions.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      apply(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    // Clean reset, then reset asserted mid-pulse with a pending FP reservation.
    @(posedge clk); #3;
    rst_n = 1'b0; mon_en = 1'b0;
    exp_q.delete();
    m_rr = '0; m_fx = '0;
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 5'd4);
    @(negedge clk);
    apply(1'b1, 5'd9, 32'hCAFE_0009, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #2;
    check("pre_rst_we", 64'(rr_we), 64'd1);
    check("pre_rst_busy_fp", 64'(rr_busy_fp), 64'h10);
    #1;
    rst_n = 1'b0; mon_en = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    m_rr = '0; m_fx = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_0F0F, 1'b1, 5'd0, 8'h5A, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    @(negedge clk);
    apply_idle();
    @(posedge clk); #2;
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
